nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_if.sv | 39 +++
 rtl/nibble_serial_adder.sv | 159 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder_if
//  Description : Operand/result handshake bundle for nibble_serial_adder.
//                Upstream side : in_valid/in_ready with operands a, b, cin.
//                Downstream side: out_valid/out_ready with sum, cout and
//                               skip_cnt (nibbles that took the skip path).
//                master - the environment driving operands and accepting
//                         results; slave - the adder itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
) ();
    localparam int N     = WIDTH / 4;
    localparam int CNT_W = $clog2(N + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [CNT_W-1:0] skip_cnt;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, skip_cnt
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, skip_cnt
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : Serial adder processing one 4-bit carry-skip slice per clock.
//                An accepted operand set takes exactly N = WIDTH/4 cycles,
//                after which the result is held with out_valid until the
//                downstream handshake. No input buffering: in_ready is only
//                high while idle.
//  Ports       : clk       - clock, rising edge
//                rst       - synchronous active-high reset
//                bus.slave - in_valid/in_ready, a, b, cin,
//                            out_valid/out_ready, sum, cout, skip_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    nibble_serial_adder_if.slave bus
);
    localparam int N     = WIDTH / 4;
    localparam int CNT_W = $clog2(N + 1);
    localparam int K_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [K_W-1:0] c_K_LAST = K_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [K_W-1:0]   r_k;
    logic [CNT_W-1:0] r_skip;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_p;
    logic [3:0]       w_s;
    logic             w_ripple_c;
    logic             w_skip;
    logic             w_nib_cout;
    logic             w_last;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_last = (r_k == c_K_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Ready is masked by reset so nothing is claimed accepted
                // on an edge that is about to clear the block.
                w_in_ready = ~rst;
                if (bus.in_valid && w_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Carry-skip nibble slice
    // ------------------------------------------------------------------
    assign w_a_nib = r_a[{r_k, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_k, 2'b00} +: 4];
    assign w_p     = w_a_nib ^ w_b_nib;

    always_comb begin
        logic w_c;
        w_c = r_carry;
        w_s = 4'd0;
        for (int i = 0; i < 4; i++) begin
            w_s[i] = w_p[i] ^ w_c;
            w_c    = (w_a_nib[i] & w_b_nib[i]) | (w_c & w_p[i]);
        end
        w_ripple_c = w_c;
    end

    // When every bit propagates, the incoming carry bypasses the ripple chain.
    assign w_skip     = &w_p;
    assign w_nib_cout = w_skip ? r_carry : w_ripple_c;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_skip  <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_carry <= bus.cin;
                r_sum   <= '0;
                r_k     <= '0;
                r_skip  <= '0;
            end else if (r_state == S_RUN) begin
                r_sum[{r_k, 2'b00} +: 4] <= w_s;
                r_carry                  <= w_nib_cout;
                r_skip                   <= r_skip + CNT_W'(w_skip);
                if (!w_last) begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_carry;
    assign bus.skip_cnt  = r_skip;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_adder
//  Description : Self-checking bench for nibble_serial_adder (WIDTH=16).
//                Directed cases plus a randomized stream compared against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;
    localparam int WIDTH = 16;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) ifc ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer addition and a count of all-propagate nibbles.
    function automatic logic [16:0] ref_sum(input logic [15:0] ra, input logic [15:0] rb, input logic rc);
        return {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
    endfunction

    function automatic logic [2:0] ref_skip(input logic [15:0] ra, input logic [15:0] rb);
        int n;
        logic [15:0] x;
        n = 0;
        x = ra ^ rb;
        for (int i = 0; i < 4; i++) begin
            if (((x >> (4 * i)) & 16'h000F) == 16'h000F) n++;
        end
        return 3'(n);
    endfunction

    // One directed operation: accept, measure latency, check result, hold the
    // result for 'hold' cycles with out_ready low, then hand it off while a
    // stray in_valid is present.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input int hold);
        logic [16:0] exp;
        logic [2:0]  exps;
        int          cyc;
        exp  = ref_sum(ta, tb, tc);
        exps = ref_skip(ta, tb);
        @(negedge clk);
        chk({tag, ":in_ready_idle"}, 32'(ifc.in_ready), 32'd1);
        ifc.in_valid  = 1'b1;
        ifc.a         = ta;
        ifc.b         = tb;
        ifc.cin       = tc;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        ifc.a        = 16'($urandom);
        ifc.b        = 16'($urandom);
        ifc.cin      = ~tc;
        chk({tag, ":in_ready_run"}, 32'(ifc.in_ready), 32'd0);
        cyc = 0;
        while (!ifc.out_valid && cyc < 20) begin
            @(negedge clk);
            ifc.in_valid = 1'b1;
            cyc++;
        end
        chk({tag, ":latency"}, 32'(cyc), 32'd4);
        chk({tag, ":sum"}, 32'(ifc.sum), 32'(exp[15:0]));
        chk({tag, ":cout"}, 32'(ifc.cout), 32'(exp[16]));
        chk({tag, ":skip"}, 32'(ifc.skip_cnt), 32'(exps));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            ifc.in_valid = 1'b1;
            ifc.a        = 16'($urandom);
            chk({tag, ":hold_valid"}, 32'(ifc.out_valid), 32'd1);
            chk({tag, ":hold_in_ready"}, 32'(ifc.in_ready), 32'd0);
            chk({tag, ":hold_result"}, {12'd0, ifc.skip_cnt, ifc.cout, ifc.sum},
                {12'd0, exps, exp});
        end
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ":post_valid"}, 32'(ifc.out_valid), 32'd0);
        chk({tag, ":post_in_ready"}, 32'(ifc.in_ready), 32'd1);
        chk({tag, ":post_result"}, {12'd0, ifc.skip_cnt, ifc.cout, ifc.sum}, {12'd0, exps, exp});
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
    endtask

    initial begin
        logic [16:0] q_res[$];
        logic [2:0]  q_skip[$];
        logic [16:0] e_res;
        logic [2:0]  e_skip;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        int          acc;
        int          got;
        int          cyc;
        int          seen;

        n_chk         = 0;
        n_fail        = 0;
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.cin       = 1'b0;
        ifc.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst:in_ready", 32'(ifc.in_ready), 32'd0);
        chk("rst:out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst:outputs", {12'd0, ifc.skip_cnt, ifc.cout, ifc.sum}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst:in_ready_after", 32'(ifc.in_ready), 32'd1);

        // Directed cases
        do_op("basic",     16'h1234, 16'h4321, 1'b1, 0);
        do_op("wrap",      16'hFFFF, 16'h0001, 1'b0, 0);
        do_op("allskip1",  16'hF0F0, 16'h0F0F, 1'b1, 0);
        do_op("allskip0",  16'hF0F0, 16'h0F0F, 1'b0, 0);
        do_op("backpress", 16'hABCD, 16'h5432, 1'b1, 3);

        // Reset in the middle of an operation (at k=2)
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.a        = 16'h7777;
        ifc.b        = 16'h8888;
        ifc.cin      = 1'b1;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (ifc.out_valid) seen++;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort:in_ready_in_rst", 32'(ifc.in_ready), 32'd0);
        chk("abort:out_valid", 32'(ifc.out_valid), 32'd0);
        chk("abort:outputs", {12'd0, ifc.skip_cnt, ifc.cout, ifc.sum}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort:in_ready_after", 32'(ifc.in_ready), 32'd1);
        repeat (6) begin
            @(negedge clk);
            if (ifc.out_valid) seen++;
        end
        chk("abort:no_result", 32'(seen), 32'd0);
        do_op("after_abort", 16'h0001, 16'h0001, 1'b0, 0);

        // Random back-to-back stream with random downstream backpressure
        acc = 0;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            ifc.out_ready = 1'($urandom);
            if (ifc.out_valid && ifc.out_ready) begin
                if (q_res.size() == 0) begin
                    chk("rand:unexpected_result", 32'd1, 32'd0);
                end else begin
                    e_res  = q_res.pop_front();
                    e_skip = q_skip.pop_front();
                    chk("rand:cout_sum", {15'd0, ifc.cout, ifc.sum}, {15'd0, e_res});
                    chk("rand:skip", 32'(ifc.skip_cnt), 32'(e_skip));
                    got++;
                end
            end
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            // Bias some operands toward propagate-heavy patterns.
            if (($urandom % 4) == 0) rb = ~ra ^ 16'($urandom_range(0, 15));
            ifc.a   = ra;
            ifc.b   = rb;
            ifc.cin = rc;
            if (ifc.in_ready && acc < 1000) begin
                ifc.in_valid = 1'b1;
                q_res.push_back(ref_sum(ra, rb, rc));
                q_skip.push_back(ref_skip(ra, rb));
                acc++;
            end else if (acc < 1000) begin
                ifc.in_valid = 1'($urandom);
            end else begin
                ifc.in_valid = 1'b0;
            end
        end
        chk("rand:results_count", 32'(got), 32'd1000);
        chk("rand:scoreboard_vs_accepts", 32'(got), 32'(acc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
